// File: rtl/dds_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dds_pkg
// Brief   : Shared constants and state encoding for the DDS sweep sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package dds_pkg;

  // Default tuning-word width, matching the dds_gen FreqWord input
  localparam int N_DEFAULT = 24;

  // Sweep mode encodings; 2'b11 is handled as a single sweep
  localparam logic [1:0] MODE_SINGLE   = 2'b00;
  localparam logic [1:0] MODE_REPEAT   = 2'b01;
  localparam logic [1:0] MODE_PINGPONG = 2'b10;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DWELL  = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/dds_dwell_timer.sv
`default_nettype none
// ============================================================================
// Module  : dds_dwell_timer
// Brief   : Loadable down-counter with terminal-count flag. Sets how long
//           each tuning word is held.
// Revision: 1.0 - initial release
// ============================================================================
module dds_dwell_timer #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] load_val,
  output logic          tc
);

  logic [DW-1:0] count_q;
  logic [DW-1:0] count_d;

  // Load has priority; otherwise count down and rest at zero
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/dds_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : dds_sweep_ctrl
// Brief   : Frequency-word sequencer feeding dds_gen. Steps FreqWord from a
//           start to a stop word with a fixed increment and a programmable
//           hold per word. Single, repeating and ping-pong sweeps.
// Revision: 1.0 - initial release
// ============================================================================
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [1:0]    mode,
  input  logic [N-1:0]  f_start,
  input  logic [N-1:0]  f_stop,
  input  logic [N-1:0]  f_step,
  input  logic [DW-1:0] dwell,
  output logic [N-1:0]  FreqWord,
  output logic          busy,
  output logic          done,
  output logic          step_tick
);

  state_e        state_q,     state_d;
  logic [N-1:0]  fw_q,        fw_d;
  logic          busy_q,      busy_d;
  logic          done_q,      done_d;
  logic          tick_q,      tick_d;
  logic [N-1:0]  start_lat_q, start_lat_d;
  logic [N-1:0]  stop_lat_q,  stop_lat_d;
  logic [N-1:0]  step_lat_q,  step_lat_d;
  logic [1:0]    mode_lat_q,  mode_lat_d;
  logic [DW-1:0] reload_q,    reload_d;   // D-1, the per-word timer reload
  logic          dir_up_q,    dir_up_d;

  logic          timer_load;
  logic [DW-1:0] timer_val;
  logic          timer_tc;

  // One step from cur toward stop, saturating at stop. The extra MSB keeps
  // N-bit wrap-around from looking like a small in-range value.
  function automatic logic [N-1:0] step_toward(input logic [N-1:0] cur,
                                               input logic [N-1:0] stp,
                                               input logic [N-1:0] lim,
                                               input logic         up);
    logic [N:0] nxt;
    if (up) begin
      nxt = {1'b0, cur} + {1'b0, stp};
      if (nxt >= {1'b0, lim}) nxt = {1'b0, lim};
    end else begin
      nxt = {1'b0, cur} - {1'b0, stp};
      if (nxt[N] || (nxt[N-1:0] <= lim)) nxt = {1'b0, lim};
    end
    return nxt[N-1:0];
  endfunction

  dds_dwell_timer #(.DW(DW)) u_dwell_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_val),
    .tc       (timer_tc)
  );

  // Next-state and next-output logic for the sweep sequencer
  always_comb begin
    state_d     = state_q;
    fw_d        = fw_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    tick_d      = 1'b0;
    start_lat_d = start_lat_q;
    stop_lat_d  = stop_lat_q;
    step_lat_d  = step_lat_q;
    mode_lat_d  = mode_lat_q;
    reload_d    = reload_q;
    dir_up_d    = dir_up_q;
    timer_load  = 1'b0;
    timer_val   = reload_q;

    case (state_q)
      ST_IDLE: begin
        if (!abort && start) begin
          start_lat_d = f_start;
          stop_lat_d  = (f_step == '0) ? f_start : f_stop;
          step_lat_d  = f_step;
          mode_lat_d  = mode;
          dir_up_d    = (f_stop >= f_start);
          reload_d    = (dwell == '0) ? '0 : dwell - 1'b1;
          timer_val   = reload_d;
          timer_load  = 1'b1;
          fw_d        = f_start;
          busy_d      = 1'b1;
          state_d     = ST_DWELL;
        end
      end

      ST_DWELL: begin
        if (abort) begin
          fw_d    = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (timer_tc) begin
          if (fw_q != stop_lat_q) begin
            fw_d       = step_toward(fw_q, step_lat_q, stop_lat_q, dir_up_q);
            tick_d     = 1'b1;
            timer_load = 1'b1;
          end else begin
            case (mode_lat_q)
              MODE_REPEAT: begin
                fw_d       = start_lat_q;
                tick_d     = 1'b1;
                timer_load = 1'b1;
              end
              MODE_PINGPONG: begin
                // Reverse: old start becomes the new target
                start_lat_d = stop_lat_q;
                stop_lat_d  = start_lat_q;
                dir_up_d    = !dir_up_q;
                fw_d        = step_toward(fw_q, step_lat_q, start_lat_q, !dir_up_q);
                tick_d      = 1'b1;
                timer_load  = 1'b1;
              end
              default: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_FINISH;
              end
            endcase
          end
        end
      end

      ST_FINISH: begin
        if (abort) begin
          fw_d = '0;
        end
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        fw_d    = '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latched sweep settings and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      fw_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tick_q      <= 1'b0;
      start_lat_q <= '0;
      stop_lat_q  <= '0;
      step_lat_q  <= '0;
      mode_lat_q  <= '0;
      reload_q    <= '0;
      dir_up_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      fw_q        <= fw_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      tick_q      <= tick_d;
      start_lat_q <= start_lat_d;
      stop_lat_q  <= stop_lat_d;
      step_lat_q  <= step_lat_d;
      mode_lat_q  <= mode_lat_d;
      reload_q    <= reload_d;
      dir_up_q    <= dir_up_d;
    end
  end

  assign FreqWord  = fw_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign step_tick = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_dds_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_dds_sweep_ctrl
// Brief   : Self-checking bench for dds_sweep_ctrl using a table of sweep
//           records plus hand-written abort, reset and idle sequences.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dds_sweep_ctrl;
  import dds_pkg::*;

  localparam int N  = 24;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [N-1:0]  f_start = '0;
  logic [N-1:0]  f_stop = '0;
  logic [N-1:0]  f_step = '0;
  logic [DW-1:0] dwell = '0;
  logic [N-1:0]  FreqWord;
  logic          busy;
  logic          done;
  logic          step_tick;

  int n_cmp = 0;
  int n_err = 0;

  dds_sweep_ctrl #(.N(N), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .mode      (mode),
    .f_start   (f_start),
    .f_stop    (f_stop),
    .f_step    (f_step),
    .dwell     (dwell),
    .FreqWord  (FreqWord),
    .busy      (busy),
    .done      (done),
    .step_tick (step_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]        md;
    logic [N-1:0]      fs;
    logic [N-1:0]      fe;
    logic [N-1:0]      st;
    logic [DW-1:0]     dw;
    int                n;
    logic [6:0][N-1:0] ex;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [1:0] md, input logic [N-1:0] fs,
                              input logic [N-1:0] fe, input logic [N-1:0] st,
                              input logic [DW-1:0] dw, input int n,
                              input logic [N-1:0] e0, input logic [N-1:0] e1,
                              input logic [N-1:0] e2, input logic [N-1:0] e3,
                              input logic [N-1:0] e4, input logic [N-1:0] e5,
                              input logic [N-1:0] e6);
    vec_t v;
    v.md = md; v.fs = fs; v.fe = fe; v.st = st; v.dw = dw; v.n = n;
    v.ex[0] = e0; v.ex[1] = e1; v.ex[2] = e2; v.ex[3] = e3;
    v.ex[4] = e4; v.ex[5] = e5; v.ex[6] = e6;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic chk_idle(input string nm, input logic [N-1:0] fw);
    chk({nm, "_freq"}, 32'(FreqWord), 32'(fw));
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_done"}, 32'(done), 32'd0);
    chk({nm, "_tick"}, 32'(step_tick), 32'd0);
  endtask

  // Run one table record; optionally poke start and other inputs mid-sweep
  task automatic run_vec(input vec_t v, input bit disturb);
    int d;
    d = (v.dw == '0) ? 1 : int'(v.dw);
    mode = v.md; f_start = v.fs; f_stop = v.fe; f_step = v.st; dwell = v.dw;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int w = 0; w < v.n; w++) begin
      for (int c = 0; c < d; c++) begin
        if (disturb && w == 1 && c == 0) begin
          start = 1'b1; f_start = 24'd7; f_stop = 24'd9; f_step = 24'd1;
          mode = MODE_REPEAT; dwell = 16'd1;
        end else begin
          start = 1'b0;
        end
        chk("freq", 32'(FreqWord), 32'(v.ex[w]));
        chk("busy", 32'(busy), 32'd1);
        chk("done_early", 32'(done), 32'd0);
        chk("step_tick", 32'(step_tick), (w > 0 && c == 0) ? 32'd1 : 32'd0);
        @(negedge clk);
      end
    end
    start = 1'b0;
    if (v.md == MODE_REPEAT || v.md == MODE_PINGPONG) begin
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk_idle("after_abort", '0);
      @(negedge clk);
      chk_idle("after_abort2", '0);
    end else begin
      chk("done_pulse", 32'(done), 32'd1);
      chk("done_busy", 32'(busy), 32'd0);
      chk("done_freq", 32'(FreqWord), 32'(v.ex[v.n-1]));
      chk("done_tick", 32'(step_tick), 32'd0);
      @(negedge clk);
      chk_idle("post_done", v.ex[v.n-1]);
    end
  endtask

  initial begin
    vecs[0]  = mk(2'b00, 24'd50,  24'd200, 24'd50, 16'd4, 4, 24'd50, 24'd100, 24'd150, 24'd200, 0, 0, 0);
    vecs[1]  = mk(2'b00, 24'd50,  24'd180, 24'd50, 16'd1, 4, 24'd50, 24'd100, 24'd150, 24'd180, 0, 0, 0);
    vecs[2]  = mk(2'b00, 24'd200, 24'd50,  24'd75, 16'd2, 3, 24'd200, 24'd125, 24'd50, 0, 0, 0, 0);
    vecs[3]  = mk(2'b00, 24'hFFFF00, 24'hFFFFFF, 24'h000080, 16'd1, 3,
                  24'hFFFF00, 24'hFFFF80, 24'hFFFFFF, 0, 0, 0, 0);
    vecs[4]  = mk(2'b00, 24'h000080, 24'h000010, 24'h000100, 16'd2, 2,
                  24'h000080, 24'h000010, 0, 0, 0, 0, 0);
    vecs[5]  = mk(2'b01, 24'd50, 24'd150, 24'd50, 16'd2, 7,
                  24'd50, 24'd100, 24'd150, 24'd50, 24'd100, 24'd150, 24'd50);
    vecs[6]  = mk(2'b10, 24'd50, 24'd150, 24'd50, 16'd2, 7,
                  24'd50, 24'd100, 24'd150, 24'd100, 24'd50, 24'd100, 24'd150);
    vecs[7]  = mk(2'b00, 24'd50, 24'd150, 24'd50, 16'd0, 3, 24'd50, 24'd100, 24'd150, 0, 0, 0, 0);
    vecs[8]  = mk(2'b00, 24'd50, 24'd999, 24'd0, 16'd3, 1, 24'd50, 0, 0, 0, 0, 0, 0);
    vecs[9]  = mk(2'b00, 24'd200, 24'd200, 24'd10, 16'd3, 1, 24'd200, 0, 0, 0, 0, 0, 0);
    vecs[10] = mk(2'b11, 24'd10, 24'd30, 24'd10, 16'd1, 3, 24'd10, 24'd20, 24'd30, 0, 0, 0, 0);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk_idle("reset", '0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("reset_release", '0);

    // Table-driven sweeps
    for (int i = 0; i < NV; i++) begin
      run_vec(vecs[i], 1'b0);
      @(negedge clk);
    end

    // Start and input changes during a sweep are ignored
    run_vec(vecs[0], 1'b1);
    @(negedge clk);

    // Abort / start in IDLE: nothing happens, FreqWord keeps 200
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk_idle("abort_in_idle", 24'd200);
    mode = MODE_SINGLE; f_start = 24'd5; f_stop = 24'd9; f_step = 24'd1; dwell = 16'd1;
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    chk_idle("abort_beats_start", 24'd200);
    @(negedge clk);
    chk_idle("abort_beats_start2", 24'd200);

    // Abort in the middle of the 100 hold
    mode = vecs[0].md; f_start = vecs[0].fs; f_stop = vecs[0].fe;
    f_step = vecs[0].st; dwell = vecs[0].dw;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      chk("abort_pre_freq", 32'(FreqWord), (c < 4) ? 32'd50 : 32'd100);
      @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk_idle("abort_mid", '0);
      @(negedge clk);
    end

    // Asynchronous reset mid-sweep
    mode = MODE_REPEAT; f_start = 24'd50; f_stop = 24'd150; f_step = 24'd50; dwell = 16'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pre_freq", 32'(FreqWord), 32'd100);
    chk("rst_pre_tick", 32'(step_tick), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("async_reset", '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_idle("after_reset", '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
Frequency-word sequencer that sits directly upstream of dds_gen and drives its FreqWord input. It steps the tuning word from a start value to a stop value by a fixed increment, holding each value for a programmable number of clocks. Used for chirp/sweep stimulus and frequency-response tests without reprogramming FreqWord from outside. Modes are single sweep, repeating sweep and ping-pong.

Parameters:
N, 24, tuning-word width; matches dds_gen FreqWord width.
DW, 16, dwell-counter width.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a sweep; ignored while busy=1
abort  input  1  terminate the sweep; highest priority
mode  input  2  00 single, 01 repeat, 10 ping-pong, 11 treated as single
f_start  input  N  first tuning word
f_stop  input  N  last tuning word
f_step  input  N  increment magnitude (unsigned)
dwell  input  DW  clocks each word is held; 0 is treated as 1
FreqWord  output  N  tuning word to dds_gen, registered
busy  output  1  high while a sweep is active
done  output  1  one-cycle pulse at normal completion of a single sweep
step_tick  output  1  one-cycle pulse coincident with each FreqWord change after the first

Behaviour:
- Reset (async, rst_n=0): FreqWord=0, busy=0, done=0, step_tick=0, state IDLE, all latched registers 0. Reset mid-sweep returns to these values immediately. No done pulse is produced.
- Clock and reset are fixed as decided: one clock; reset is asynchronous and active-low.
- Let D = max(dwell, 1).
- States: IDLE, DWELL, FINISH.
- IDLE:
  - FreqWord holds its last value.
  - start=1 at edge k: latch f_start, f_stop, f_step, mode and D.
  - dir = up if f_stop >= f_start, else down.
  - If f_step=0, latched stop := f_start (single-point sweep).
  - After edge k: FreqWord=f_start, busy=1, dwell counter=D-1, state DWELL. step_tick stays 0.
- DWELL:
  - Counter decrements each cycle, so each word is held exactly D cycles.
  - When counter=0 and FreqWord is not equal to the latched stop: next = FreqWord ± step, computed in N+1 bits.
  - If next would cross or equal stop, next := stop (clamp). This also covers N-bit overflow and underflow.
  - FreqWord<=next, step_tick=1 for that cycle, counter reloads D-1.
  - When counter=0 and FreqWord equals stop:
    - single: go to FINISH.
    - repeat: FreqWord<=latched start, step_tick=1, reload counter.
    - ping-pong: swap the latched start and stop, invert dir, take a step toward the new stop, step_tick=1.
  - repeat and ping-pong run until abort.
- FINISH: done=1 for exactly one cycle, busy=0 in that same cycle, then IDLE. FreqWord holds stop.
- abort=1 in DWELL or FINISH: at the next edge go to IDLE with busy=0, FreqWord=0, no done, no step_tick. abort in IDLE has no effect. If abort and start are both high in IDLE, abort wins and the sweep does not start.
- start while busy=1 is ignored. Input changes during a sweep have no effect because all inputs are latched at start.
- Single-sweep duration: (K+1)·D cycles with busy=1, where K = ceil(|stop−start|/step). done follows the last dwell cycle by one edge.

Decomposition:
- Package dds_pkg holds:
  - N default (24);
  - mode constants MODE_SINGLE, MODE_REPEAT, MODE_PINGPONG;
  - state encoding for IDLE, DWELL, FINISH.
- One natural sub-module, dds_dwell_timer. It is a loadable down-counter with a terminal-count flag, width DW.
- Step/clamp arithmetic stays inline in dds_sweep_ctrl.

Test Plan:
- Single up sweep: f_start=50, f_stop=200, f_step=50, dwell=4, mode=00 → FreqWord 50,100,150,200, each held 4 cycles. busy stays high for 16 cycles, then done pulses once and busy=0. FreqWord remains 200.
- Clamp and down sweep:
  - 50→180, step 50 → sequence 50,100,150,180.
  - 200→50, step 75 → sequence 200,125,50.
  - step_tick pulses 3 and 2 times respectively.
- Overflow: f_start=24'hFFFF00, f_stop=24'hFFFFFF, step=24'h000080 → sequence FFFF00, FFFF80, FFFFFF with no wrap to a low value.
- Modes:
  - repeat 50→150, step 50, dwell=2 → 50,100,150,50,100,… continuously, with no done pulse.
  - ping-pong with the same settings → 50,100,150,100,50,100,…
- Abort/reset:
  - abort in the middle of the 100 hold → next edge FreqWord=0, busy=0, no done.
  - rst_n low mid-sweep → asynchronous clear of all outputs.
  - start during busy → no effect on the sequence.
- Degenerate inputs:
  - dwell=0 → each word is held 1 cycle.
  - f_step=0, f_start=50 → FreqWord=50 for D cycles, then done.
  - f_start=f_stop=200 → same single-point behaviour.
